// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and instruction-fetch handshake control.
// Optional redirect counter port enabled by defining REDIRECT_PERF_EN.
module pc_fetch_ctrl #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_in,
    input  logic              trap_req,
    input  logic [ADDR_W-1:0] trap_vect,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              imem_ack,
    output logic              imem_req,
    output logic              pc_hold,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_vect,
    output logic              fetch_valid,
    output logic              flush,
`ifdef REDIRECT_PERF_EN
    output logic [31:0]       redirect_cnt,
`endif
    output logic [1:0]        redirect_src
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_JMP  = 2'd1;
    localparam logic [1:0] SRC_BR   = 2'd2;
    localparam logic [1:0] SRC_TRAP = 2'd3;

    state_t            state_q, state_d;
    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]        pend_src_q, pend_src_d;

    logic              live_v;
    logic [ADDR_W-1:0] live_tgt;
    logic [1:0]        live_src;
    logic              live_wins;

    // Fixed-priority pick among live redirect requesters
    always_comb begin
        live_v   = trap_req | br_req | jmp_req;
        live_tgt = '0;
        live_src = SRC_NONE;
        if (trap_req) begin
            live_tgt = trap_vect;
            live_src = SRC_TRAP;
        end else if (br_req) begin
            live_tgt = br_target;
            live_src = SRC_BR;
        end else if (jmp_req) begin
            live_tgt = jmp_target;
            live_src = SRC_JMP;
        end
    end

    // Live beats pending on ties so the newest equal-rank target is used
    assign live_wins = live_v && (!pend_v_q || (live_src >= pend_src_q));

    // Next-state, pending-buffer update and PC control outputs
    always_comb begin
        state_d      = state_q;
        pend_v_d     = pend_v_q;
        pend_tgt_d   = pend_tgt_q;
        pend_src_d   = pend_src_q;
        imem_req     = 1'b0;
        pc_hold      = 1'b1;
        pc_sel       = 1'b0;
        pc_vect      = '0;
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        redirect_src = SRC_NONE;
        if (rst_n) begin
            unique case (state_q)
                BOOT: begin
                    pc_hold = 1'b0;
                    pc_sel  = 1'b1;
                    pc_vect = RESET_VECTOR;
                    state_d = FETCH;
                end
                FETCH: begin
                    imem_req = 1'b1;
                    if (!imem_ack) begin
                        if (live_v && (!pend_v_q || (live_src > pend_src_q))) begin
                            pend_v_d   = 1'b1;
                            pend_tgt_d = live_tgt;
                            pend_src_d = live_src;
                        end
                    end else if (pend_v_q || live_v) begin
                        pc_hold  = 1'b0;
                        pc_sel   = 1'b1;
                        flush    = 1'b1;
                        pend_v_d = 1'b0;
                        if (live_wins) begin
                            pc_vect      = live_tgt;
                            redirect_src = live_src;
                        end else begin
                            pc_vect      = pend_tgt_q;
                            redirect_src = pend_src_q;
                        end
                    end else if (!stall_in) begin
                        pc_hold     = 1'b0;
                        fetch_valid = 1'b1;
                    end else begin
                        fetch_valid = 1'b1;
                        state_d     = STALL;
                    end
                end
                STALL: begin
                    if (live_v) begin
                        pc_hold      = 1'b0;
                        pc_sel       = 1'b1;
                        pc_vect      = live_tgt;
                        flush        = 1'b1;
                        redirect_src = live_src;
                        state_d      = FETCH;
                    end else if (!stall_in) begin
                        pc_hold = 1'b0;
                        state_d = FETCH;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // State and pending-buffer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= '0;
            pend_src_q <= SRC_NONE;
        end else begin
            state_q    <= state_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
            pend_src_q <= pend_src_d;
        end
    end

`ifdef REDIRECT_PERF_EN
    logic [31:0] redirect_cnt_q;

    // Count applied redirects only; wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
        end else if (flush) begin
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed steps plus randomized cycles
// checked against a behavioural model of the fetch/redirect rules.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in;
    logic        trap_req, br_req, jmp_req;
    logic [31:0] trap_vect, br_target, jmp_target;
    logic        imem_ack;
    logic        imem_req, pc_hold, pc_sel, fetch_valid, flush;
    logic [31:0] pc_vect;
    logic [1:0]  redirect_src;
`ifdef REDIRECT_PERF_EN
    logic [31:0] redirect_cnt;
`endif

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.ADDR_W(32), .RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_in     (stall_in),
        .trap_req     (trap_req),
        .trap_vect    (trap_vect),
        .br_req       (br_req),
        .br_target    (br_target),
        .jmp_req      (jmp_req),
        .jmp_target   (jmp_target),
        .imem_ack     (imem_ack),
        .imem_req     (imem_req),
        .pc_hold      (pc_hold),
        .pc_sel       (pc_sel),
        .pc_vect      (pc_vect),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
`ifdef REDIRECT_PERF_EN
        .redirect_cnt (redirect_cnt),
`endif
        .redirect_src (redirect_src)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "where the fetcher is" plus a one-entry
    // remembered redirect (priority 0 = nothing remembered).
    bit          booting  = 1'b1;
    bit          stalled  = 1'b0;
    int          rem_pri  = 0;
    logic [31:0] rem_addr = '0;
    logic [31:0] m_cnt    = '0;

    // Expected outputs
    logic        e_req, e_hold, e_sel, e_fv, e_flush;
    logic [31:0] e_vect;
    logic [1:0]  e_src;

    // Plant PC driven by the DUT outputs, as the real PC register would be
    logic [31:0] pc = '0;
    logic        o_hold, o_sel, o_flush;
    logic [31:0] o_vect;
    logic [1:0]  o_src;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        int          lp;
        logic [31:0] la;
        lp = trap_req ? 3 : br_req ? 2 : jmp_req ? 1 : 0;
        la = trap_req ? trap_vect : br_req ? br_target :
             jmp_req ? jmp_target : 32'h0;
        e_req = 0; e_hold = 1; e_sel = 0; e_vect = 0;
        e_fv = 0; e_flush = 0; e_src = 0;
        if (!rst_n) return;
        if (booting) begin
            e_hold = 0; e_sel = 1; e_vect = RV;
        end else if (stalled) begin
            if (lp > 0) begin
                e_hold = 0; e_sel = 1; e_vect = la;
                e_flush = 1; e_src = 2'(lp);
            end else if (!stall_in) begin
                e_hold = 0;
            end
        end else begin
            e_req = 1;
            if (imem_ack) begin
                if (lp > 0 || rem_pri > 0) begin
                    e_hold = 0; e_sel = 1; e_flush = 1;
                    e_vect = (lp >= rem_pri) ? la : rem_addr;
                    e_src  = 2'((lp >= rem_pri) ? lp : rem_pri);
                end else begin
                    e_fv = 1;
                    e_hold = stall_in;
                end
            end
        end
    endtask

    task automatic advance();
        int          lp;
        logic [31:0] la;
        lp = trap_req ? 3 : br_req ? 2 : jmp_req ? 1 : 0;
        la = trap_req ? trap_vect : br_req ? br_target :
             jmp_req ? jmp_target : 32'h0;
        if (!rst_n) begin
            booting = 1; stalled = 0; rem_pri = 0; m_cnt = 0;
            return;
        end
        if (e_flush) m_cnt = m_cnt + 1;
        if (booting) begin
            booting = 0;
        end else if (stalled) begin
            if (lp > 0 || !stall_in) stalled = 0;
        end else if (!imem_ack) begin
            if (lp > rem_pri) begin
                rem_pri = lp; rem_addr = la;
            end
        end else if (e_flush) begin
            rem_pri = 0;
        end else if (stall_in) begin
            stalled = 1;
        end
    endtask

    // One clock: check outputs mid-cycle, then commit model and plant PC
    task automatic tick();
        #1;
        predict();
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("pc_hold", 32'(pc_hold), 32'(e_hold));
        chk("pc_sel", 32'(pc_sel), 32'(e_sel));
        chk("pc_vect", pc_vect, e_vect);
        chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("redirect_src", 32'(redirect_src), 32'(e_src));
`ifdef REDIRECT_PERF_EN
        chk("redirect_cnt", redirect_cnt, m_cnt);
`endif
        o_hold = pc_hold; o_sel = pc_sel; o_vect = pc_vect;
        o_flush = flush; o_src = redirect_src;
        @(posedge clk);
        if (!o_hold) pc = o_sel ? o_vect : pc + 32'd4;
        advance();
        @(negedge clk);
    endtask

    task automatic idle_in();
        stall_in = 0; trap_req = 0; br_req = 0; jmp_req = 0;
        trap_vect = 0; br_target = 0; jmp_target = 0;
    endtask

    initial begin
        rst_n = 0; imem_ack = 1;
        idle_in();
        @(negedge clk);

        // Reset, then boot with a redirect that must be ignored
        tick(); tick();
        rst_n = 1; trap_req = 1; trap_vect = 32'h500;
        tick();
        chk("boot_pc", pc, RV);
        idle_in();
        tick(); tick(); tick();
        chk("seq_pc", pc, 32'hC);

        // Slow memory: three-cycle transaction
        imem_ack = 0; tick(); tick();
        chk("wait_pc", pc, 32'hC);
        imem_ack = 1; tick();
        chk("ack_pc", pc, 32'h10);

        // Jump then branch during wait; branch wins at ack
        imem_ack = 0; jmp_req = 1; jmp_target = 32'h100; tick();
        jmp_req = 0; br_req = 1; br_target = 32'h200; tick();
        br_req = 0; imem_ack = 1; tick();
        chk("pend_vect", o_vect, 32'h200);
        chk("pend_src", 32'(o_src), 32'd2);
        chk("pend_pc", pc, 32'h200);

        // All three requesters on one ack cycle
        trap_req = 1; trap_vect = 32'h80;
        br_req = 1; br_target = 32'h40;
        jmp_req = 1; jmp_target = 32'h20;
        tick();
        chk("trap_src", 32'(o_src), 32'd3);
        chk("trap_pc", pc, 32'h80);
        idle_in(); tick();
        chk("flush_once", 32'(o_flush), 32'd0);

        // Steer to 0x10 then stall there
        jmp_req = 1; jmp_target = 32'h10; tick();
        idle_in(); tick();
        chk("pre_stall_pc", pc, 32'h14);
        jmp_req = 1; jmp_target = 32'h10; tick();
        idle_in(); stall_in = 1; tick(); tick(); tick();
        chk("stall_pc", pc, 32'h10);
        stall_in = 0; tick();
        chk("unstall_pc", pc, 32'h14);
        stall_in = 1; tick(); tick();
        br_req = 1; br_target = 32'h300; tick();
        chk("stall_redirect_pc", pc, 32'h300);
        chk("stall_redirect_flush", 32'(o_flush), 32'd1);
        idle_in(); tick();

        // Reset while a redirect is pending
        imem_ack = 0; jmp_req = 1; jmp_target = 32'h700; tick();
        jmp_req = 0; rst_n = 0; tick();
        rst_n = 1; imem_ack = 1; tick();
        chk("rst_boot_pc", pc, RV);
        tick();
        chk("rst_drop_pc", pc, RV + 32'd4);

        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            imem_ack   = ($urandom_range(0, 9) < 6);
            stall_in   = ($urandom_range(0, 9) < 3);
            trap_req   = ($urandom_range(0, 19) == 0);
            br_req     = ($urandom_range(0, 9) == 0);
            jmp_req    = ($urandom_range(0, 9) == 0);
            trap_vect  = $urandom & 32'hFFFF_FFFC;
            br_target  = $urandom & 32'hFFFF_FFFC;
            jmp_target = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
